yarp_seq_ctrl: RTL
==================

// Module: yarp_seq_ctrl
// PURPOSE
//  Multi-cycle sequencer for the yarp RV32I datapath. Steps each instruction through fetch,
//  decode, execute, optional data-memory access and writeback, driving every datapath enable.
//  Sits between the instruction/data memory ports and the regfile/ALU/PC datapath.
//  Also produces alu_op_t selects and a retired-instruction count.
// PARAMETERS
//  BUS_TIMEOUT  255  max cycles any memory handshake may stall before trapping (1..2^16-1)
//  RET_CNT_W    32   width of retired-instruction counter
// PORTS
//  clk            in   1     single clock, all state on rising edge
//  reset          in   1     synchronous, active-high
//  imem_req_o     out  1     instruction fetch request
//  imem_gnt_i     in   1     fetch request accepted
//  imem_rvalid_i  in   1     fetch data valid
//  dmem_req_o     out  1     data request
//  dmem_wr_o      out  1     1=store, 0=load; valid while dmem_req_o
//  dmem_gnt_i     in   1     data request accepted
//  dmem_rvalid_i  in   1     load data valid / store complete
//  opcode_i       in   7     IR[6:0], riscv_op_t
//  funct3_i       in   3     IR[14:12]
//  funct7b5_i     in   1     IR[30]
//  br_taken_i     in   1     branch comparator result, valid in EXECUTE
//  ir_we_o        out  1     load IR
//  alu_op_o       out  4     alu_op_t
//  rf_we_o        out  1     regfile write enable
//  pc_we_o        out  1     PC update enable
//  pc_sel_o       out  1     0=PC+4, 1=ALU result (jump / taken branch)
//  trap_o         out  1     sticky: illegal opcode or bus timeout
//  trap_cause_o   out  2     0=none 1=illegal 2=imem timeout 3=dmem timeout
//  retired_o      out  RET_CNT_W  instructions retired since reset
// BEHAVIOUR
//  - Reset: state=FETCH_REQ; all outputs 0, alu_op_o=OP_ADD; timer and retired_o cleared.
//    Reset mid-handshake abandons it; no pending pulses survive.
//  - FSM: FETCH_REQ -> FETCH_WAIT -> DECODE -> EXECUTE -> {MEM_REQ -> MEM_WAIT ->} WRITEBACK -> FETCH_REQ; TRAP absorbing.
//  - FETCH_REQ: imem_req_o=1 held until imem_gnt_i; gnt -> FETCH_WAIT. rvalid with gnt is
//    ignored; fetch data is taken only in FETCH_WAIT.
//  - FETCH_WAIT: on imem_rvalid_i pulse ir_we_o 1 cycle, -> DECODE.
//  - DECODE: opcode not in riscv_op_t -> TRAP, cause 1. Else -> EXECUTE.
//  - EXECUTE: alu_op_o valid (registered, held until next DECODE). I_TYPE_0 / S_TYPE -> MEM_REQ,
//    others -> WRITEBACK.
//  - MEM_REQ: dmem_req_o=1, dmem_wr_o=(S_TYPE), held until dmem_gnt_i -> MEM_WAIT.
//  - MEM_WAIT: on dmem_rvalid_i -> WRITEBACK.
//  - WRITEBACK, one cycle: pc_we_o=1, retired_o++ (wraps modulo 2^RET_CNT_W).
//    rf_we_o=1 unless S_TYPE / B_TYPE. pc_sel_o=1 for J_TYPE, I_TYPE_2, B_TYPE with
//    br_taken_i sampled in EXECUTE.
//  - ALU map (R_TYPE / I_TYPE_1 by funct3):
//    000 ADD (SUB if R_TYPE & f7b5); 001 SLL; 010 SLT; 011 SLTU; 100 XOR;
//    101 SRL (SRA if f7b5, both types); 110 OR; 111 AND.
//  - ALU map (other opcodes): B_TYPE funct3 00x SUB, 10x SLT, 11x SLTU, 01x illegal -> TRAP;
//    I_TYPE_0/S_TYPE/I_TYPE_2/U_TYPE_*/J_TYPE -> ADD.
//  - Timeout: counter clears on entry to FETCH_REQ/FETCH_WAIT/MEM_REQ/MEM_WAIT, +1 per stalled
//    cycle. On reaching BUS_TIMEOUT -> TRAP (cause 2 imem, 3 dmem); requests drop next cycle.
//    Completion on the same cycle as expiry wins.
//  - TRAP: all enables/requests 0, trap_o=1; only reset exits.
//  - Min latency with gnt same cycle and rvalid next cycle: 5 cycles ALU/branch/jump, 7 load/store.
// STRUCTURE
//  - yarp_pkg gains ctrl_state_t (FSM enum) and trap_cause_t; reuses riscv_op_t and alu_op_t.
//  - One natural sub-module: yarp_alu_dec (combinational opcode/funct3/f7b5 -> alu_op_t + illegal).
//  - FSM, timeout timer and retired counter stay in this module.
// TESTING
//  - ADD x (op 33, f3 0, f7b5 0), gnt/rvalid zero-wait -> ir_we@2, alu_op=OP_ADD, rf_we+pc_we@4, retired=1.
//  - R_TYPE f3 5 f7b5 1 -> OP_SRA; I_TYPE_1 f3 0 f7b5 1 -> OP_ADD; R f3 0 f7b5 1 -> OP_SUB.
//  - Load (op 03), dmem_gnt delayed 3 cycles -> dmem_req held 4 cycles, dmem_wr=0, rf_we=1; 10 cycles total.
//  - B_TYPE f3 0, br_taken=1 -> alu_op=OP_SUB, pc_sel=1, rf_we=0; br_taken=0 -> pc_sel=0.
//  - Opcode 7'h7F -> trap_o=1 cause 1 after DECODE; later gnt/rvalid ignored, no further pc_we.
//  - BUS_TIMEOUT=4, gnt never -> trap cause 2, imem_req_o low after 4 stalled cycles.
//  - Reset asserted in MEM_WAIT -> next cycle FETCH_REQ, retired cleared, dmem_req_o=0.

Source files
------------

// File: rtl/yarp_pkg.sv
// Shared types for the yarp RV32I core: opcode classes, ALU selects and sequencer state.
package yarp_pkg;

  // Major opcode classes (IR[6:0]); anything else is illegal
  typedef enum logic [6:0] {
    R_TYPE   = 7'h33,
    I_TYPE_0 = 7'h03,  // loads
    I_TYPE_1 = 7'h13,  // ALU immediate
    I_TYPE_2 = 7'h67,  // JALR
    S_TYPE   = 7'h23,
    B_TYPE   = 7'h63,
    U_TYPE_0 = 7'h37,  // LUI
    U_TYPE_1 = 7'h17,  // AUIPC
    J_TYPE   = 7'h6F
  } riscv_op_t;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_SLL  = 4'd2,
    OP_SRL  = 4'd3,
    OP_SRA  = 4'd4,
    OP_OR   = 4'd5,
    OP_AND  = 4'd6,
    OP_XOR  = 4'd7,
    OP_SLTU = 4'd8,
    OP_SLT  = 4'd9
  } alu_op_t;

  typedef enum logic [2:0] {
    StFetchReq,
    StFetchWait,
    StDecode,
    StExecute,
    StMemReq,
    StMemWait,
    StWriteback,
    StTrap
  } ctrl_state_t;

  typedef enum logic [1:0] {
    CauseNone        = 2'd0,
    CauseIllegal     = 2'd1,
    CauseImemTimeout = 2'd2,
    CauseDmemTimeout = 2'd3
  } trap_cause_t;

  // Handshake stall timer width; covers the full legal BUS_TIMEOUT range
  localparam int unsigned TimerW = 16;

endpackage

// File: rtl/yarp_alu_dec.sv
// Combinational ALU-select decoder: opcode/funct3/funct7[5] -> alu_op_t plus illegal flag.
module yarp_alu_dec
  import yarp_pkg::*;
(
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  output alu_op_t    alu_op_o,
  output logic       illegal_o
);

  // Decode the ALU operation; unknown opcodes and B-type funct3 01x flag illegal
  always_comb begin
    alu_op_o  = OP_ADD;
    illegal_o = 1'b0;
    case (opcode_i)
      R_TYPE, I_TYPE_1: begin
        unique case (funct3_i)
          3'b000: alu_op_o = ((opcode_i == R_TYPE) && funct7b5_i) ? OP_SUB : OP_ADD;
          3'b001: alu_op_o = OP_SLL;
          3'b010: alu_op_o = OP_SLT;
          3'b011: alu_op_o = OP_SLTU;
          3'b100: alu_op_o = OP_XOR;
          3'b101: alu_op_o = funct7b5_i ? OP_SRA : OP_SRL;
          3'b110: alu_op_o = OP_OR;
          3'b111: alu_op_o = OP_AND;
        endcase
      end
      B_TYPE: begin
        unique case (funct3_i[2:1])
          2'b00: alu_op_o = OP_SUB;
          2'b01: illegal_o = 1'b1;
          2'b10: alu_op_o = OP_SLT;
          2'b11: alu_op_o = OP_SLTU;
        endcase
      end
      I_TYPE_0, S_TYPE, I_TYPE_2, U_TYPE_0, U_TYPE_1, J_TYPE: alu_op_o = OP_ADD;
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/yarp_seq_ctrl.sv
// Multi-cycle sequencer for the yarp RV32I datapath: fetch, decode, execute, optional memory
// access and writeback, with a handshake stall timer, sticky trap and retired counter.
module yarp_seq_ctrl
  import yarp_pkg::*;
#(
  parameter int unsigned BUS_TIMEOUT = 255,
  parameter int unsigned RET_CNT_W   = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic                 imem_req_o,
  input  logic                 imem_gnt_i,
  input  logic                 imem_rvalid_i,
  output logic                 dmem_req_o,
  output logic                 dmem_wr_o,
  input  logic                 dmem_gnt_i,
  input  logic                 dmem_rvalid_i,
  input  logic [6:0]           opcode_i,
  input  logic [2:0]           funct3_i,
  input  logic                 funct7b5_i,
  input  logic                 br_taken_i,
  output logic                 ir_we_o,
  output alu_op_t              alu_op_o,
  output logic                 rf_we_o,
  output logic                 pc_we_o,
  output logic                 pc_sel_o,
  output logic                 trap_o,
  output logic [1:0]           trap_cause_o,
  output logic [RET_CNT_W-1:0] retired_o
);

  ctrl_state_t           state_q;
  trap_cause_t           cause_q;
  alu_op_t               alu_op_q;
  logic [TimerW-1:0]     timer_q;
  logic [RET_CNT_W-1:0]  retired_q;
  logic                  imem_req_q, dmem_req_q, dmem_wr_q, ir_we_q;
  logic                  rf_we_q, pc_we_q, pc_sel_q, trap_q;
  // Instruction class, captured at DECODE so later phases do not depend on IR stability
  logic                  is_mem_q, is_store_q, no_rf_q, is_jump_q, is_branch_q;

  alu_op_t               dec_alu_op;
  logic                  dec_illegal;
  logic                  timer_exp;

  yarp_alu_dec u_alu_dec (
    .opcode_i   (opcode_i),
    .funct3_i   (funct3_i),
    .funct7b5_i (funct7b5_i),
    .alu_op_o   (dec_alu_op),
    .illegal_o  (dec_illegal)
  );

  // Expiry is flagged on the last allowed stalled cycle so the trap lands after BUS_TIMEOUT
  always_comb begin
    timer_exp = (timer_q == TimerW'(BUS_TIMEOUT - 1));
  end

  // Sequencer FSM with registered outputs, stall timer and retired counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StFetchReq;
      cause_q     <= CauseNone;
      alu_op_q    <= OP_ADD;
      timer_q     <= '0;
      retired_q   <= '0;
      imem_req_q  <= 1'b0;
      dmem_req_q  <= 1'b0;
      dmem_wr_q   <= 1'b0;
      ir_we_q     <= 1'b0;
      rf_we_q     <= 1'b0;
      pc_we_q     <= 1'b0;
      pc_sel_q    <= 1'b0;
      trap_q      <= 1'b0;
      is_mem_q    <= 1'b0;
      is_store_q  <= 1'b0;
      no_rf_q     <= 1'b0;
      is_jump_q   <= 1'b0;
      is_branch_q <= 1'b0;
    end else begin
      // Single-cycle strobes default low
      ir_we_q  <= 1'b0;
      rf_we_q  <= 1'b0;
      pc_we_q  <= 1'b0;
      pc_sel_q <= 1'b0;
      case (state_q)
        StFetchReq: begin
          if (!imem_req_q) begin
            // First cycle out of reset: raise the request, nothing can be granted yet
            imem_req_q <= 1'b1;
          end else if (imem_gnt_i) begin
            imem_req_q <= 1'b0;
            timer_q    <= '0;
            state_q    <= StFetchWait;
          end else if (timer_exp) begin
            imem_req_q <= 1'b0;
            trap_q     <= 1'b1;
            cause_q    <= CauseImemTimeout;
            state_q    <= StTrap;
          end else begin
            timer_q <= timer_q + TimerW'(1);
          end
        end
        StFetchWait: begin
          if (imem_rvalid_i) begin
            ir_we_q <= 1'b1;
            state_q <= StDecode;
          end else if (timer_exp) begin
            trap_q  <= 1'b1;
            cause_q <= CauseImemTimeout;
            state_q <= StTrap;
          end else begin
            timer_q <= timer_q + TimerW'(1);
          end
        end
        StDecode: begin
          if (dec_illegal) begin
            trap_q  <= 1'b1;
            cause_q <= CauseIllegal;
            state_q <= StTrap;
          end else begin
            alu_op_q    <= dec_alu_op;
            is_mem_q    <= (opcode_i == I_TYPE_0) || (opcode_i == S_TYPE);
            is_store_q  <= (opcode_i == S_TYPE);
            no_rf_q     <= (opcode_i == S_TYPE) || (opcode_i == B_TYPE);
            is_jump_q   <= (opcode_i == J_TYPE) || (opcode_i == I_TYPE_2);
            is_branch_q <= (opcode_i == B_TYPE);
            state_q     <= StExecute;
          end
        end
        StExecute: begin
          if (is_mem_q) begin
            dmem_req_q <= 1'b1;
            dmem_wr_q  <= is_store_q;
            timer_q    <= '0;
            state_q    <= StMemReq;
          end else begin
            // Branch outcome is only valid now, so the PC select is resolved here
            rf_we_q   <= !no_rf_q;
            pc_we_q   <= 1'b1;
            pc_sel_q  <= is_jump_q || (is_branch_q && br_taken_i);
            retired_q <= retired_q + RET_CNT_W'(1);
            state_q   <= StWriteback;
          end
        end
        StMemReq: begin
          if (dmem_gnt_i) begin
            dmem_req_q <= 1'b0;
            dmem_wr_q  <= 1'b0;
            timer_q    <= '0;
            state_q    <= StMemWait;
          end else if (timer_exp) begin
            dmem_req_q <= 1'b0;
            dmem_wr_q  <= 1'b0;
            trap_q     <= 1'b1;
            cause_q    <= CauseDmemTimeout;
            state_q    <= StTrap;
          end else begin
            timer_q <= timer_q + TimerW'(1);
          end
        end
        StMemWait: begin
          if (dmem_rvalid_i) begin
            rf_we_q   <= !no_rf_q;
            pc_we_q   <= 1'b1;
            retired_q <= retired_q + RET_CNT_W'(1);
            state_q   <= StWriteback;
          end else if (timer_exp) begin
            trap_q  <= 1'b1;
            cause_q <= CauseDmemTimeout;
            state_q <= StTrap;
          end else begin
            timer_q <= timer_q + TimerW'(1);
          end
        end
        StWriteback: begin
          imem_req_q <= 1'b1;
          timer_q    <= '0;
          state_q    <= StFetchReq;
        end
        StTrap: begin
          // Absorbing; only reset leaves
        end
      endcase
    end
  end

  assign imem_req_o   = imem_req_q;
  assign dmem_req_o   = dmem_req_q;
  assign dmem_wr_o    = dmem_wr_q;
  assign ir_we_o      = ir_we_q;
  assign alu_op_o     = alu_op_q;
  assign rf_we_o      = rf_we_q;
  assign pc_we_o      = pc_we_q;
  assign pc_sel_o     = pc_sel_q;
  assign trap_o       = trap_q;
  assign trap_cause_o = cause_q;
  assign retired_o    = retired_q;

endmodule
